// File: rtl/adrv9001_enable_sequencer.sv
// -----------------------------------------------------------------------------
// adrv9001_enable_sequencer
//
// Purpose:
//   Drives the ADRV9001 control pins. After power-up, and again on a software
//   reset request, it runs a device reset pulse and a settle interval. It then
//   turns the PS-side level requests into registered, glitch-free RX/TX enables.
//   Each channel enforces RX/TX mutual exclusion and an all-off guard interval
//   on every turnaround.
//
// Optional feature (compile-time macro):
//   ADRV9001_SEQ_TDD_INTERLOCK_EN - cross-channel TDD interlock. TX entry on
//   either channel needs both channels clear of RX (on or guarding after RX),
//   and RX entry likewise. Channel 1 wins same-cycle opposite-direction
//   entries. When the macro is undefined, the channels are fully independent.
//
// Handshake:
//   There is no valid/ready handshake. rx_req and tx_req are level requests and
//   are only sampled while the sequencer is in RUN. reset_req is a single-cycle
//   pulse. ready is a status level, not a flow-control signal.
//
// Ports:
//   clk               in   control clock
//   rstn              in   asynchronous active-low reset
//   reset_req         in   pulse: restart the device reset sequence
//   rx_req[1:0]       in   level RX enable request, bit n = channel n+1
//   tx_req[1:0]       in   level TX enable request, bit n = channel n+1
//   adrv9001_rstn     out  device reset pin, active low
//   adrv9001_rx1/rx2  out  RX enables
//   adrv9001_tx1/tx2  out  TX enables
//   ready             out  device settled, requests honoured
//   ch_busy[1:0]      out  channel n is on or guarding
//   conflict[1:0]     out  sticky: both requests high while channel idle
//   o_dbg_top_state   out  top FSM state (0 pulse, 1 settle, 2 run)
//   o_dbg_ch_state    out  {ch2, ch1} channel FSM states, 3 bits each
//                          (0 idle, 1 rx_on, 2 tx_on, 3 guard_rx, 4 guard_tx)
// -----------------------------------------------------------------------------
module adrv9001_enable_sequencer #(
    parameter int RSTN_PULSE_CYCLES = 1000,
    parameter int SETTLE_CYCLES     = 2000,
    parameter int GUARD_CYCLES      = 64,
    parameter int CNT_W             = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       reset_req,
    input  logic [1:0] rx_req,
    input  logic [1:0] tx_req,
    output logic       adrv9001_rstn,
    output logic       adrv9001_rx1,
    output logic       adrv9001_rx2,
    output logic       adrv9001_tx1,
    output logic       adrv9001_tx2,
    output logic       ready,
    output logic [1:0] ch_busy,
    output logic [1:0] conflict,
    output logic [1:0] o_dbg_top_state,
    output logic [5:0] o_dbg_ch_state
);

    typedef enum logic [1:0] {TOP_RST_PULSE = 2'd0, TOP_RST_SETTLE = 2'd1, TOP_RUN = 2'd2} top_state_t;
    typedef enum logic [2:0] {CH_IDLE = 3'd0, CH_RX_ON = 3'd1, CH_TX_ON = 3'd2,
                              CH_GUARD_RX = 3'd3, CH_GUARD_TX = 3'd4} ch_state_t;

    localparam int P_PULSE  = (RSTN_PULSE_CYCLES < 1) ? 1 : RSTN_PULSE_CYCLES;
    localparam int P_SETTLE = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int P_GUARD  = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;

    // The pulse counts P_PULSE edges in RST_PULSE. Settle stays one edge longer,
    // so ready rises on the edge after the settle interval ends.
    localparam logic [CNT_W-1:0] C_PULSE_LAST  = CNT_W'(P_PULSE - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(P_SETTLE);
    // The guard counter reaches 0 on the last guard cycle. The one IDLE cycle
    // after it makes the all-off window GUARD_CYCLES+1 cycles long.
    localparam logic [CNT_W-1:0] C_GUARD_LOAD  = CNT_W'(P_GUARD - 1);

    // ------------------------------------------------------------------ top FSM
    top_state_t       r_top_state, w_top_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_pin, r_ready;

    always_comb begin
        w_top_next = r_top_state;
        w_cnt_next = r_cnt;
        case (r_top_state)
            TOP_RST_PULSE: begin
                if (r_cnt == C_PULSE_LAST) begin
                    w_top_next = TOP_RST_SETTLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            TOP_RST_SETTLE: begin
                if (r_cnt == C_SETTLE_LAST) begin
                    w_top_next = TOP_RUN;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            TOP_RUN: w_cnt_next = '0;
            default: begin
                w_top_next = TOP_RST_PULSE;
                w_cnt_next = '0;
            end
        endcase
        if (reset_req) begin
            w_top_next = TOP_RST_PULSE;
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_top_state <= TOP_RST_PULSE;
            r_cnt       <= '0;
            r_pin       <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_top_state <= w_top_next;
            r_cnt       <= w_cnt_next;
            r_pin       <= (w_top_next != TOP_RST_PULSE);
            r_ready     <= (w_top_next == TOP_RUN);
        end
    end

    // A reset request overrides the same-cycle channel decisions, so the
    // channels are gated with it as well as with the registered RUN state.
    logic w_run;
    assign w_run = (r_top_state == TOP_RUN) && !reset_req;

    // -------------------------------------------------------------- channel FSMs
    ch_state_t        r_ch_state [2];
    ch_state_t        w_ch_next  [2];
    logic [CNT_W-1:0] r_gcnt     [2];
    logic [CNT_W-1:0] w_gcnt_next[2];
    logic [1:0]       r_rx, r_tx, r_busy, r_conflict, w_conflict_set;
    logic [1:0]       w_rx_allowed, w_tx_allowed;

`ifdef ADRV9001_SEQ_TDD_INTERLOCK_EN
    logic w_any_rx_busy, w_any_tx_busy, w_ch1_enter_rx, w_ch1_enter_tx;
    // A channel that is on, or still guarding after that direction, blocks the
    // opposite direction on both channels.
    assign w_any_rx_busy = (r_ch_state[0] == CH_RX_ON) || (r_ch_state[0] == CH_GUARD_RX) ||
                           (r_ch_state[1] == CH_RX_ON) || (r_ch_state[1] == CH_GUARD_RX);
    assign w_any_tx_busy = (r_ch_state[0] == CH_TX_ON) || (r_ch_state[0] == CH_GUARD_TX) ||
                           (r_ch_state[1] == CH_TX_ON) || (r_ch_state[1] == CH_GUARD_TX);
    // Channel 1 entries taken this cycle; channel 2 yields to them.
    assign w_ch1_enter_rx = w_run && (r_ch_state[0] == CH_IDLE) && rx_req[0] && !tx_req[0] && !w_any_tx_busy;
    assign w_ch1_enter_tx = w_run && (r_ch_state[0] == CH_IDLE) && tx_req[0] && !rx_req[0] && !w_any_rx_busy;
    assign w_rx_allowed = {!w_any_tx_busy && !w_ch1_enter_tx, !w_any_tx_busy};
    assign w_tx_allowed = {!w_any_rx_busy && !w_ch1_enter_rx, !w_any_rx_busy};
`else
    assign w_rx_allowed = 2'b11;
    assign w_tx_allowed = 2'b11;
`endif

    always_comb begin
        w_conflict_set = '0;
        for (int n = 0; n < 2; n++) begin
            w_ch_next[n]   = r_ch_state[n];
            w_gcnt_next[n] = r_gcnt[n];
            case (r_ch_state[n])
                CH_IDLE: begin
                    if (rx_req[n] && tx_req[n])
                        w_conflict_set[n] = 1'b1;
                    else if (rx_req[n] && w_rx_allowed[n])
                        w_ch_next[n] = CH_RX_ON;
                    else if (tx_req[n] && w_tx_allowed[n])
                        w_ch_next[n] = CH_TX_ON;
                end
                CH_RX_ON: begin
                    if (!rx_req[n]) begin
                        w_ch_next[n]   = CH_GUARD_RX;
                        w_gcnt_next[n] = C_GUARD_LOAD;
                    end
                end
                CH_TX_ON: begin
                    if (!tx_req[n]) begin
                        w_ch_next[n]   = CH_GUARD_TX;
                        w_gcnt_next[n] = C_GUARD_LOAD;
                    end
                end
                CH_GUARD_RX, CH_GUARD_TX: begin
                    if (r_gcnt[n] == '0)
                        w_ch_next[n] = CH_IDLE;
                    else
                        w_gcnt_next[n] = r_gcnt[n] - CNT_W'(1);
                end
                default: begin
                    w_ch_next[n]   = CH_IDLE;
                    w_gcnt_next[n] = '0;
                end
            endcase
            if (!w_run) begin
                w_ch_next[n]      = CH_IDLE;
                w_gcnt_next[n]    = '0;
                w_conflict_set[n] = 1'b0;
            end
        end
    end

    // Enables are registered from the next state, so pins change exactly on
    // the state-change edge and are never decoded combinationally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < 2; n++) begin
                r_ch_state[n] <= CH_IDLE;
                r_gcnt[n]     <= '0;
            end
            r_rx       <= '0;
            r_tx       <= '0;
            r_busy     <= '0;
            r_conflict <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                r_ch_state[n] <= w_ch_next[n];
                r_gcnt[n]     <= w_gcnt_next[n];
                r_rx[n]       <= (w_ch_next[n] == CH_RX_ON);
                r_tx[n]       <= (w_ch_next[n] == CH_TX_ON);
                r_busy[n]     <= (w_ch_next[n] != CH_IDLE);
            end
            r_conflict <= reset_req ? 2'b00 : (r_conflict | w_conflict_set);
        end
    end

    assign adrv9001_rstn   = r_pin;
    assign ready           = r_ready;
    assign adrv9001_rx1    = r_rx[0];
    assign adrv9001_rx2    = r_rx[1];
    assign adrv9001_tx1    = r_tx[0];
    assign adrv9001_tx2    = r_tx[1];
    assign ch_busy         = r_busy;
    assign conflict        = r_conflict;
    assign o_dbg_top_state = r_top_state;
    assign o_dbg_ch_state  = {r_ch_state[1], r_ch_state[0]};

endmodule

// File: tb/tb_adrv9001_enable_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adrv9001_enable_sequencer
//
// Directed bench for adrv9001_enable_sequencer with RSTN_PULSE_CYCLES=8,
// SETTLE_CYCLES=4 and GUARD_CYCLES=3. Inputs change 1 time unit after a rising
// edge. Outputs are checked at that same point, so they show the registers
// updated by the edge just passed. The packed output vector is
// {adrv9001_rstn, ready, tx2, tx1, rx2, rx1, ch_busy[1:0], conflict[1:0]}.
// -----------------------------------------------------------------------------
module tb_adrv9001_enable_sequencer;

`ifdef ADRV9001_SEQ_TDD_INTERLOCK_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    // ------------------------------------------------------- clock and reset
    logic       clk = 1'b0;
    logic       rstn;
    logic       reset_req;
    logic [1:0] rx_req, tx_req;
    logic       adrv9001_rstn, adrv9001_rx1, adrv9001_rx2, adrv9001_tx1, adrv9001_tx2, ready;
    logic [1:0] ch_busy, conflict, dbg_top_state;
    logic [5:0] dbg_ch_state;

    always #5 clk = ~clk;

    adrv9001_enable_sequencer #(
        .RSTN_PULSE_CYCLES(8),
        .SETTLE_CYCLES    (4),
        .GUARD_CYCLES     (3),
        .CNT_W            (16)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .reset_req      (reset_req),
        .rx_req         (rx_req),
        .tx_req         (tx_req),
        .adrv9001_rstn  (adrv9001_rstn),
        .adrv9001_rx1   (adrv9001_rx1),
        .adrv9001_rx2   (adrv9001_rx2),
        .adrv9001_tx1   (adrv9001_tx1),
        .adrv9001_tx2   (adrv9001_tx2),
        .ready          (ready),
        .ch_busy        (ch_busy),
        .conflict       (conflict),
        .o_dbg_top_state(dbg_top_state),
        .o_dbg_ch_state (dbg_ch_state)
    );

    // ------------------------------------------------------------ scoreboard
    int          checks   = 0;
    int          failures = 0;
    logic [9:0]  exp_q[$];

    function automatic logic [9:0] mk(input logic pin, input logic rdy, input logic t2, input logic t1,
                                      input logic r2, input logic r1, input logic [1:0] busy,
                                      input logic [1:0] conf);
        return {pin, rdy, t2, t1, r2, r1, busy, conf};
    endfunction

    task automatic check_outs(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {adrv9001_rstn, ready, adrv9001_tx2, adrv9001_tx1, adrv9001_rx2, adrv9001_rx1, ch_busy, conflict};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ----------------------------------------------------------- driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] rx, input logic [1:0] tx);
        rx_req = rx;
        tx_req = tx;
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        rstn      = 1'b1;
        reset_req = 1'b0;
        drive_req(2'b00, 2'b00);
        #3 rstn = 1'b0;
        #1;
        check_outs("reset_values", 10'b0);
        check_val("reset_dbg_top", {6'b0, dbg_top_state}, 8'd0);
        check_val("reset_dbg_ch", {2'b0, dbg_ch_state}, 8'd0);

        // Power-up: the pin is low for 8 edges, then ready follows 5 edges later.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 13; k++)
            exp_q.push_back(mk(k >= 8, k >= 13, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        for (int k = 1; k <= 13; k++) begin
            step();
            check_outs($sformatf("powerup_k%0d", k), exp_q.pop_front());
        end
        check_val("run_dbg_top", {6'b0, dbg_top_state}, 8'd2);

        // Channel 1 turnaround: rx for 10 cycles, then tx as rx drops.
        drive_req(2'b01, 2'b00);
        for (int i = 1; i <= 10; i++) begin
            step();
            check_outs($sformatf("rx1_on_%0d", i), mk(1, 1, 0, 0, 0, 1, 2'b01, 2'b00));
        end
        drive_req(2'b00, 2'b01);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_outs($sformatf("guard_%0d", i), mk(1, 1, 0, 0, 0, 0, {1'b0, i <= 3}, 2'b00));
        end
        step();
        check_outs("tx1_after_guard", mk(1, 1, 0, 1, 0, 0, 2'b01, 2'b00));
        drive_req(2'b00, 2'b00);
        repeat (5) step();
        check_outs("tx1_released", mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00));

        // Conflict on channel 2 is sticky.
        drive_req(2'b10, 2'b10);
        step();
        check_outs("conflict_set", mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b10));
        drive_req(2'b00, 2'b00);
        repeat (2) step();
        check_outs("conflict_sticky", mk(1, 1, 0, 0, 0, 0, 2'b00, 2'b10));

        // Cross-channel: rx1 active, then tx on channel 2.
        drive_req(2'b01, 2'b00);
        step();
        check_outs("xch_rx1_on", mk(1, 1, 0, 0, 0, 1, 2'b01, 2'b10));
        drive_req(2'b01, 2'b10);
        step();
        check_outs("xch_tx2_req", mk(1, 1, !IL, 0, 0, 1, {!IL, 1'b1}, 2'b10));
        drive_req(2'b00, 2'b10);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_outs($sformatf("xch_guard_%0d", i), mk(1, 1, !IL, 0, 0, 0, {!IL, i <= 3}, 2'b10));
        end
        step();
        check_outs("xch_tx2_on", mk(1, 1, 1, 0, 0, 0, 2'b10, 2'b10));

        // Software reset with tx2 active; tx_req[1] stays high throughout.
        reset_req = 1'b1;
        step();
        reset_req = 1'b0;
        check_outs("reset_req_k1", mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        for (int k = 2; k <= 15; k++) begin
            step();
            check_outs($sformatf("reset_req_k%0d", k),
                       mk(k >= 9, k >= 14, k >= 15, 0, 0, 0, {k >= 15, 1'b0}, 2'b00));
        end

        // Asynchronous reset in the middle of a channel 2 guard.
        drive_req(2'b00, 2'b00);
        step();
        check_outs("guard2_start", mk(1, 1, 0, 0, 0, 0, 2'b10, 2'b00));
        #3 rstn = 1'b0;
        #1;
        check_outs("async_reset", 10'b0);
        check_val("async_dbg_ch", {2'b0, dbg_ch_state}, 8'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_outs($sformatf("restart_k%0d", k), mk(k >= 8, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
